// File: rtl/timestamp_mem_loader_pkg.sv
// Shared timing-core definitions for the timestamp/active-pixel table loader.
package timestamp_mem_loader_pkg;

    typedef enum logic {
        LD_LOAD = 1'b0,
        LD_DONE = 1'b1
    } ld_state_t;

    localparam int ACTIVE_BIT = 16;
    localparam int TS_MSB     = 15;
    localparam int MAX_GRP    = 4;

    // Out-of-range frame counts collapse onto the highest physical group.
    function automatic int clamp_grp(input int n, input int max_grp);
        return (n > max_grp) ? max_grp : n;
    endfunction

endpackage

// File: rtl/timestamp_mem_loader_ld_addr_counter.sv
// Address/group counter pair; flags the last entry of a frame and of the whole set.
module ld_addr_counter #(
    parameter int ADDR_W = 11,
    parameter int SEL_W  = 3
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              step,
    input  logic [ADDR_W-1:0] last_addr,
    input  logic [SEL_W-1:0]  last_grp,
    output logic [ADDR_W-1:0] addr_cnt,
    output logic [SEL_W-1:0]  grp_cnt,
    output logic              frame_end,
    output logic              set_end
);

    assign frame_end = (addr_cnt == last_addr);
    assign set_end   = frame_end && (grp_cnt == last_grp);

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            addr_cnt <= '0;
            grp_cnt  <= '0;
        end else if (step) begin
            if (frame_end) begin
                addr_cnt <= '0;
                grp_cnt  <= set_end ? '0 : grp_cnt + 1'b1;
            end else begin
                addr_cnt <= addr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/timestamp_mem_loader.sv
// Shadow-bank writer: streams a table set into groups 0..N, then waits for the bank swap.
module timestamp_mem_loader
    import timestamp_mem_loader_pkg::*;
#(
    parameter int ADDR_W  = 11,
    parameter int DATA_W  = 17,
    parameter int SEL_W   = 3,
    parameter int MAX_GRP = 4
) (
    input  logic              clk_i,
    input  logic              nrst_i,
    input  logic              s_valid_i,
    input  logic [DATA_W-1:0] s_data_i,
    input  logic              s_last_i,
    output logic              s_ready_o,
    input  logic [ADDR_W-1:0] entries_per_frame_i,
    input  logic [SEL_W-1:0]  number_of_frames_i,
    input  logic              update_mem_i,
    output logic [ADDR_W-1:0] waddr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              wen_o,
    output logic [SEL_W-1:0]  memory_selector_o,
    output logic              mem_updated_o,
    output logic              load_err_o
);

    ld_state_t         state;
    logic              upd_ref;
    logic              accept;
    logic [SEL_W-1:0]  last_grp;
    logic [ADDR_W-1:0] addr_cnt;
    logic [SEL_W-1:0]  grp_cnt;
    logic              frame_end;
    logic              set_end;

    assign accept   = s_valid_i & s_ready_o;
    assign last_grp = SEL_W'(clamp_grp(int'(number_of_frames_i), MAX_GRP));

    ld_addr_counter #(
        .ADDR_W (ADDR_W),
        .SEL_W  (SEL_W)
    ) u_cnt (
        .clk_i     (clk_i),
        .nrst_i    (nrst_i),
        .step      (accept),
        .last_addr (entries_per_frame_i),
        .last_grp  (last_grp),
        .addr_cnt  (addr_cnt),
        .grp_cnt   (grp_cnt),
        .frame_end (frame_end),
        .set_end   (set_end)
    );

    always_ff @(posedge clk_i or negedge nrst_i) begin
        if (!nrst_i) begin
            state             <= LD_LOAD;
            upd_ref           <= 1'b0;
            s_ready_o         <= 1'b0;
            wen_o             <= 1'b0;
            waddr_o           <= '0;
            wdata_o           <= '0;
            memory_selector_o <= '0;
            mem_updated_o     <= 1'b0;
            load_err_o        <= 1'b0;
        end else begin
            wen_o <= accept;
            if (accept) begin
                waddr_o           <= addr_cnt;
                wdata_o           <= s_data_i;
                memory_selector_o <= grp_cnt;
                if (s_last_i != frame_end)
                    load_err_o <= 1'b1;
            end

            case (state)
                LD_LOAD: begin
                    if (accept && set_end) begin
                        // Reference taken here, so a toggle coincident with the final beat is not a release.
                        state     <= LD_DONE;
                        upd_ref   <= update_mem_i;
                        s_ready_o <= 1'b0;
                    end else begin
                        s_ready_o <= 1'b1;
                    end
                end
                LD_DONE: begin
                    if (update_mem_i != upd_ref) begin
                        state         <= LD_LOAD;
                        mem_updated_o <= 1'b0;
                        s_ready_o     <= 1'b1;
                    end else begin
                        // Rises one cycle after the final write lands.
                        mem_updated_o <= 1'b1;
                    end
                end
                default: state <= LD_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_timestamp_mem_loader.sv
// Scoreboard bench: driver queues expected writes, a negedge monitor pops and compares.
module tb_timestamp_mem_loader;

    logic        clk_i = 1'b0;
    logic        nrst_i;
    logic        s_valid_i;
    logic [16:0] s_data_i;
    logic        s_last_i;
    logic        s_ready_o;
    logic [10:0] entries_per_frame_i;
    logic [2:0]  number_of_frames_i;
    logic        update_mem_i;
    logic [10:0] waddr_o;
    logic [16:0] wdata_o;
    logic        wen_o;
    logic [2:0]  memory_selector_o;
    logic        mem_updated_o;
    logic        load_err_o;

    int nvec = 0;
    int nerr = 0;
    int wr_count = 0;
    logic [30:0] exp_q[$];

    always #5 clk_i = ~clk_i;

    timestamp_mem_loader dut (
        .clk_i               (clk_i),
        .nrst_i              (nrst_i),
        .s_valid_i           (s_valid_i),
        .s_data_i            (s_data_i),
        .s_last_i            (s_last_i),
        .s_ready_o           (s_ready_o),
        .entries_per_frame_i (entries_per_frame_i),
        .number_of_frames_i  (number_of_frames_i),
        .update_mem_i        (update_mem_i),
        .waddr_o             (waddr_o),
        .wdata_o             (wdata_o),
        .wen_o               (wen_o),
        .memory_selector_o   (memory_selector_o),
        .mem_updated_o       (mem_updated_o),
        .load_err_o          (load_err_o)
    );

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: every write must match the oldest outstanding expectation.
    always @(negedge clk_i) begin
        if (nrst_i === 1'b1 && wen_o === 1'b1) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {1'b0, memory_selector_o, waddr_o, wdata_o}, 32'hffff_ffff);
            end else begin
                logic [30:0] e;
                e = exp_q.pop_front();
                chk("write", {1'b0, memory_selector_o, waddr_o, wdata_o}, {1'b0, e});
                chk("sel_range", 32'(memory_selector_o <= 3'd4), 32'd1);
            end
        end
    end

    // Called right after a negedge; returns right after the negedge following acceptance.
    task automatic send(input logic [16:0] d, input logic last, input logic [30:0] e);
        bit done;
        done = 0;
        s_valid_i = 1'b1;
        s_data_i  = d;
        s_last_i  = last;
        for (int t = 0; t <= 200 && !done; t++) begin
            if (t == 200) begin
                chk("ready_timeout", 32'd0, 32'd1);
            end else if (s_ready_o === 1'b1) begin
                exp_q.push_back(e);
                @(negedge clk_i);
                done = 1;
            end else begin
                @(negedge clk_i);
            end
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    // Reference model: beat i of a set goes to group i/(epf+1), address i%(epf+1).
    task automatic run_load(input int epf, input int nf, input int gap_pct,
                            input int nbeats, input int bad_idx, input bit seq_data);
        int ngrp, total, n, addr, grp;
        logic [16:0] d;
        logic last;
        entries_per_frame_i = 11'(epf);
        number_of_frames_i  = 3'(nf);
        ngrp  = (nf > 4) ? 5 : nf + 1;
        total = (epf + 1) * ngrp;
        n     = (nbeats < 0) ? total : nbeats;
        for (int i = 0; i < n; i++) begin
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) @(negedge clk_i);
            d    = seq_data ? 17'(i) : 17'($urandom);
            addr = i % (epf + 1);
            grp  = i / (epf + 1);
            last = (addr == epf) ^ (i == bad_idx);
            if (i == total - 1)
                chk("mem_upd_before_final", 32'(mem_updated_o), 32'd0);
            send(d, last, {3'(grp), 11'(addr), d});
        end
        if (n == total) begin
            chk("ready_after_final", 32'(s_ready_o), 32'd0);
            chk("mem_upd_with_last_write", 32'(mem_updated_o), 32'd0);
            @(negedge clk_i);
            chk("mem_upd_rise", 32'(mem_updated_o), 32'd1);
            chk("ready_in_done", 32'(s_ready_o), 32'd0);
        end
    endtask

    task automatic release_bank();
        update_mem_i = ~update_mem_i;
        @(negedge clk_i);
        chk("mem_upd_fall", 32'(mem_updated_o), 32'd0);
        chk("ready_after_swap", 32'(s_ready_o), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, bad;
        nrst_i = 1'b0;
        s_valid_i = 1'b0;
        s_data_i = '0;
        s_last_i = 1'b0;
        entries_per_frame_i = 11'd3;
        number_of_frames_i = 3'd1;
        update_mem_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("rst_outputs", {1'b0, s_ready_o, wen_o, mem_updated_o, load_err_o, memory_selector_o, waddr_o, 14'd0}, 32'd0);
        chk("rst_wdata", 32'(wdata_o), 32'd0);
        nrst_i = 1'b1;

        // Directed 2x4 load with sequential data, then a long DONE hold.
        run_load(3, 1, 0, -1, -1, 1);
        s_valid_i = 1'b1;
        s_data_i = 17'h1ffff;
        bad = 0;
        repeat (50) begin
            @(negedge clk_i);
            if (mem_updated_o !== 1'b1 || s_ready_o !== 1'b0) bad++;
        end
        s_valid_i = 1'b0;
        chk("done_hold", 32'(bad), 32'd0);
        release_bank();

        // 3 frames of 5 entries, gapless then 50% gaps.
        w0 = wr_count;
        run_load(4, 2, 0, -1, -1, 1);
        chk("gapless_count", 32'(wr_count - w0), 32'd15);
        release_bank();
        w0 = wr_count;
        run_load(4, 2, 50, -1, -1, 1);
        chk("gapped_count", 32'(wr_count - w0), 32'd15);
        release_bank();

        // Misplaced s_last sets the sticky error without disturbing addressing.
        chk("err_clear", 32'(load_err_o), 32'd0);
        run_load(3, 0, 0, -1, 2, 0);
        chk("err_set", 32'(load_err_o), 32'd1);
        release_bank();
        run_load(3, 0, 30, -1, -1, 0);
        chk("err_sticky", 32'(load_err_o), 32'd1);
        release_bank();

        // number_of_frames_i above the legal range clamps to 5 groups.
        run_load(1, 7, 20, -1, -1, 0);
        release_bank();

        // Asynchronous reset after 6 of 8 beats restarts the set.
        run_load(3, 1, 0, 6, -1, 0);
        nrst_i = 1'b0;
        #1;
        chk("midload_rst", {1'b0, s_ready_o, wen_o, mem_updated_o, load_err_o, memory_selector_o, waddr_o, 14'd0}, 32'd0);
        chk("midload_rst_wdata", 32'(wdata_o), 32'd0);
        exp_q.delete();
        @(negedge clk_i);
        nrst_i = 1'b1;
        run_load(3, 1, 0, -1, -1, 1);
        release_bank();

        // Random configurations, including single-entry frames.
        for (int k = 0; k < 6; k++) begin
            run_load((k == 0) ? 0 : int'($urandom_range(5)), int'($urandom_range(7)), 50, -1, -1, 0);
            release_bank();
        end

        repeat (3) @(negedge clk_i);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/timestamp_mem_loader.md
Name: timestamp_mem_loader

Overview:
- Write-side producer for the double-buffered timestamp/active-pixel memory groups in the timing core.
- Accepts a valid/ready stream of 17-bit table entries: bit 16 = active pixel, bits 15:0 = timestamp ticks.
- Writes the entries sequentially into frame groups 0..number_of_frames_i of the shadow bank.
- Then raises mem_updated_o and holds it until the memory manager swaps banks (update_mem_i toggles), after which it accepts the next table set.

Parameters:
ADDR_W, 11, write address width (entries per frame up to 2048)
DATA_W, 17, entry width ({active_pixel, timestamp[15:0]})
SEL_W, 3, memory group selector width
MAX_GRP, 4, highest legal group index (5 groups)

Ports:
clk_i  in  1  system clock
nrst_i  in  1  asynchronous active-low reset
s_valid_i  in  1  input entry valid
s_data_i  in  DATA_W  input entry
s_last_i  in  1  marks last entry of a frame table
s_ready_o  out  1  loader accepts entry this cycle
entries_per_frame_i  in  ADDR_W  entries per frame minus one (last address)
number_of_frames_i  in  SEL_W  last group index to load; values >MAX_GRP clamp to MAX_GRP
update_mem_i  in  1  bank-select flag from memory manager
waddr_o  out  ADDR_W  write address
wdata_o  out  DATA_W  write data
wen_o  out  1  write enable, one cycle per entry
memory_selector_o  out  SEL_W  target group
mem_updated_o  out  1  shadow bank complete, swap permitted
load_err_o  out  1  sticky: s_last_i position mismatched count

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low (nrst_i).
- Reset values: all outputs 0. Internal address counter 0, group counter 0, state LOAD.
- State LOAD:
  - s_ready_o = 1.
  - Accepted beat (s_valid_i & s_ready_o) registers wen_o=1, waddr_o=addr_cnt, wdata_o=s_data_i, memory_selector_o=grp_cnt on the next edge (1-cycle latency, fully registered outputs).
  - With no accepted beat, wen_o=0 next cycle. waddr_o, wdata_o and memory_selector_o hold their last values.
- Frame end: when an accepted beat has addr_cnt == entries_per_frame_i, addr_cnt wraps to 0.
  - If grp_cnt == clamped number_of_frames_i: grp_cnt -> 0 and state -> DONE.
  - Otherwise grp_cnt increments.
- s_last_i checking:
  - s_last_i on a non-final beat, or its absence on the final beat, sets load_err_o (sticky until reset).
  - The address count alone defines frame boundaries; s_last_i never resets counters.
- Entering DONE: capture update_mem_i into upd_ref. mem_updated_o=1 from the cycle after the final write; s_ready_o=0.
- State DONE: remain until update_mem_i != upd_ref, then state -> LOAD. mem_updated_o falls to 0 on that same edge.
  - The manager swaps only at a new line, so DONE may last many lines. Input backpressure is held indefinitely.
- The last write (wen_o) always precedes mem_updated_o rising by at least one cycle.
- entries_per_frame_i and number_of_frames_i are sampled per beat; changing them mid-load is illegal (undefined table, no lockup).
- A clamped number_of_frames_i of 0 gives single-group loads: DONE after entries_per_frame_i+1 beats.
- entries_per_frame_i = 0: every beat is a frame end.
- Asynchronous reset mid-load or mid-DONE: immediate return to reset values. The partially written bank is not flagged; the next load restarts at group 0, address 0.
- Simultaneous final beat and update_mem_i toggle: the toggle is ignored. upd_ref is captured on the DONE-entry edge, so only a subsequent toggle releases.

Decomposition:
- Shared package (timing core defines): state encodings LD_LOAD=1'b0, LD_DONE=1'b1; entry field positions (ACTIVE_BIT=16, TS_MSB=15); MAX_GRP.
- One natural sub-module: ld_addr_counter, the address/group counter pair with frame-end and set-end flags.
- Everything else (FSM, output registers, error flag) lives in the top level.

Test Plan:
- Reset, then entries_per_frame_i=3, number_of_frames_i=1, 8 back-to-back beats 0x00000..0x00007 -> wen_o pulses with waddr 0,1,2,3,0,1,2,3 and selector 0,0,0,0,1,1,1,1. mem_updated_o=1 the cycle after the 8th write; s_ready_o=0.
- In DONE, hold update_mem_i for 50 cycles -> mem_updated_o stays 1, no wen_o. Toggle update_mem_i 1->0 -> mem_updated_o=0 and s_ready_o=1 next cycle; next beat writes waddr 0, selector 0.
- Random s_valid_i gaps (50% duty) with 3 frames of 5 entries -> writes are identical in order and content to the gapless run; wen_o count = 15.
- s_last_i asserted on beat index 2 of a 4-entry frame -> load_err_o=1 and stays 1. Addressing is unaffected (frame still ends at waddr 3).
- number_of_frames_i=7 -> selector reaches 4 then DONE (5 groups); selector never exceeds 4.
- nrst_i low for 1 cycle after 6 beats of a 2x4 load -> all outputs 0 immediately. The next beat writes waddr 0, selector 0, and mem_updated_o stays 0 until 8 further beats.
